// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC generation, imem request/response tracking, {pc, instr} buffer to IF/ID.
// Optional macro IF_MISALIGN_CHECK_EN: misaligned redirect targets raise a sticky flag and halt fetch.
module if_fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          BUF_DEPTH       = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] PC_IF,
  output logic [31:0] instr_IF,
  output logic        fetch_misaligned
);

  localparam int AW  = $clog2(BUF_DEPTH);
  localparam int CW  = AW + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW-1:0]  C1      = CW'(1);
  localparam logic [AW-1:0]  P1      = AW'(1);
  localparam logic [CW-1:0]  MAX_C   = CW'(MAX_OUTSTANDING);
  localparam logic [CW1-1:0] DEPTH_C = CW1'(BUF_DEPTH);
  localparam logic [31:0]    NOP     = 32'h0000_0013;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  logic [31:0]   fetch_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] buf_cnt;
  logic [CW-1:0] live;
  logic [AW-1:0] pq_wr, pq_rd, buf_wr, buf_rd;
  logic [31:0]   pq_pc   [BUF_DEPTH];
  logic [31:0]   buf_pc  [BUF_DEPTH];
  logic [31:0]   buf_ins [BUF_DEPTH];
  logic          misaligned;
  logic          req_fire, drop_now, rsp_keep, pop;
  logic [31:0]   redirect_tgt;
  logic          redirect_bad;

`ifdef IF_MISALIGN_CHECK_EN
  assign redirect_bad = redirect_pc[1:0] != 2'b00;
  assign redirect_tgt = redirect_pc;
`else
  assign redirect_bad = 1'b0;
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

  // Live requests plus buffered entries never exceed the buffer, so every live response has a slot.
  assign live           = inflight - drop_cnt;
  assign imem_req_valid = rst_n && !redirect_valid && !misaligned && (inflight < MAX_C)
                          && (({1'b0, live} + {1'b0, buf_cnt}) < DEPTH_C);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign drop_now       = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_keep       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

  assign if_valid         = buf_cnt != '0;
  assign pop              = if_valid && if_ready && !redirect_valid;
  assign PC_IF            = if_valid ? buf_pc[buf_rd]  : '0;
  assign instr_IF         = if_valid ? buf_ins[buf_rd] : NOP;
  assign fetch_misaligned = misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      inflight   <= '0;
      drop_cnt   <= '0;
      buf_cnt    <= '0;
      pq_wr      <= '0;
      pq_rd      <= '0;
      buf_wr     <= '0;
      buf_rd     <= '0;
      misaligned <= 1'b0;
    end else begin
      inflight <= inflight + (req_fire ? C1 : '0) - (imem_rsp_valid ? C1 : '0);
      if (redirect_valid) begin
        // Everything still outstanding (minus a response landing now) is stale.
        fetch_pc   <= redirect_tgt;
        drop_cnt   <= inflight - (imem_rsp_valid ? C1 : '0);
        buf_cnt    <= '0;
        pq_wr      <= '0;
        pq_rd      <= '0;
        buf_wr     <= '0;
        buf_rd     <= '0;
        misaligned <= redirect_bad;
      end else begin
        if (req_fire) begin
          fetch_pc <= next_pc(fetch_pc);
          pq_wr    <= pq_wr + P1;
        end
        if (drop_now) drop_cnt <= drop_cnt - C1;
        if (rsp_keep) begin
          pq_rd  <= pq_rd + P1;
          buf_wr <= buf_wr + P1;
        end
        if (pop) buf_rd <= buf_rd + P1;
        buf_cnt <= buf_cnt + (rsp_keep ? C1 : '0) - (pop ? C1 : '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pq_pc[pq_wr] <= fetch_pc;
    if (rsp_keep) begin
      buf_pc[buf_wr]  <= pq_pc[pq_rd];
      buf_ins[buf_wr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a fixed-latency in-order instruction memory model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] PC_IF;
  logic [31:0] instr_IF;
  logic        fetch_misaligned;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  int cyc = 0;

  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t        mq[$];
  logic [31:0] req_log[$];
  logic [31:0] out_pc[$];
  logic [31:0] out_ins[$];

  typedef struct {
    int          lat;
    int          warm;
    logic [31:0] target;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;
  vec_t vecs[5];

  if_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .PC_IF(PC_IF), .instr_IF(instr_IF),
    .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  // Memory drives responses just after the edge; requests and consumed outputs are logged at negedge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) mq.delete();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    @(negedge clk);
    if (rst_n && imem_req_valid && imem_req_ready) begin
      mq.push_back('{imem_req_addr, cyc + lat});
      req_log.push_back(imem_req_addr);
    end
    if (rst_n && if_valid && if_ready && !redirect_valid) begin
      out_pc.push_back(PC_IF);
      out_ins.push_back(instr_IF);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_outs(input int n, input string name);
    int t;
    t = 0;
    while (out_pc.size() < n && t < 200) begin
      step(1);
      t++;
    end
    if (out_pc.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d outputs expected %0d", name, out_pc.size(), n);
    end
  endtask

  function automatic logic [31:0] got_pc(input int i);
    return (i < out_pc.size()) ? out_pc[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] got_ins(input int i);
    return (i < out_ins.size()) ? out_ins[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    #1;
    check("rst if_valid", {31'b0, if_valid}, 32'd0);
    check("rst req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst PC_IF", PC_IF, 32'h0);
    check("rst instr_IF", instr_IF, 32'h0000_0013);
    check("rst misaligned", {31'b0, fetch_misaligned}, 32'd0);
    step(2);
    out_pc.delete();
    out_ins.delete();
    req_log.delete();
    rst_n = 1'b1;
    #1;
    check("first req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("first req_addr", imem_req_addr, 32'h0000_0000);
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    out_pc.delete();
    out_ins.delete();
    req_log.delete();
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    step(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1, 8, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
    vecs[1] = '{3, 8, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
    vecs[2] = '{1, 5, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{2, 6, 32'h0000_1000, 32'h0000_1000, 32'h0000_1004, 32'h0000_1008};
    vecs[4] = '{3, 3, 32'h8000_0040, 32'h8000_0040, 32'h8000_0044, 32'h8000_0048};

    // Streaming from reset, then back-pressure fills the buffer and must stall requests.
    lat = 1;
    do_reset();
    wait_outs(4, "stream");
    for (int i = 0; i < 4; i++) begin
      check("stream pc", got_pc(i), 32'(i * 4));
      check("stream instr", got_ins(i), mem_word(32'(i * 4)));
    end

    lat = 1;
    do_reset();
    if_ready = 1'b0;
    step(10);
    check("stall if_valid", {31'b0, if_valid}, 32'd1);
    check("stall req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("stall head pc", PC_IF, 32'h0);
    check("stall req count", 32'(req_log.size()), 32'd2);
    if_ready = 1'b1;
    wait_outs(6, "unstall");
    for (int i = 0; i < 6; i++) begin
      check("unstall pc", got_pc(i), 32'(i * 4));
      check("unstall instr", got_ins(i), mem_word(32'(i * 4)));
    end

    // Redirect table: each redirect lands in a cycle carrying a response.
    for (int v = 0; v < 5; v++) begin
      int t;
      lat = vecs[v].lat;
      do_reset();
      step(vecs[v].warm);
      t = 0;
      while (!imem_rsp_valid && t < 20) begin
        step(1);
        t++;
      end
      check("rsp at redirect", {31'b0, imem_rsp_valid}, 32'd1);
      redirect_to(vecs[v].target);
      #2;
      check("redir if_valid low", {31'b0, if_valid}, 32'd0);
      wait_outs(3, "redir");
      check("redir pc0", got_pc(0), vecs[v].exp0);
      check("redir pc1", got_pc(1), vecs[v].exp1);
      check("redir pc2", got_pc(2), vecs[v].exp2);
      check("redir ins0", got_ins(0), mem_word(vecs[v].exp0));
      check("redir ins1", got_ins(1), mem_word(vecs[v].exp1));
      check("redir ins2", got_ins(2), mem_word(vecs[v].exp2));
      check("redir first req", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, vecs[v].target);
    end

    // Misaligned redirect target.
    lat = 2;
    do_reset();
    step(6);
    redirect_to(32'h0000_0102);
`ifdef IF_MISALIGN_CHECK_EN
    step(10);
    check("misalign flag", {31'b0, fetch_misaligned}, 32'd1);
    check("misalign no req", 32'(req_log.size()), 32'd0);
    check("misalign if_valid", {31'b0, if_valid}, 32'd0);
    step(1);
    redirect_to(32'h0000_0200);
    #2;
    check("realign flag", {31'b0, fetch_misaligned}, 32'd0);
    wait_outs(2, "realign");
    check("realign pc0", got_pc(0), 32'h0000_0200);
    check("realign pc1", got_pc(1), 32'h0000_0204);
`else
    wait_outs(2, "misalign");
    check("misalign pc0", got_pc(0), 32'h0000_0100);
    check("misalign pc1", got_pc(1), 32'h0000_0104);
    check("misalign flag", {31'b0, fetch_misaligned}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
